// File: rtl/byte_route_pkg.sv
// Shared types and default sizing for the byte route scheduler.
// The index widths here describe the default configuration only.
package byte_route_pkg;

    localparam int NREQ_DEF  = 8;
    localparam int NCH_DEF   = 4;
    localparam int TMO_DEF   = 16;

    localparam int REQ_IDX_W = $clog2(NREQ_DEF);
    localparam int CH_IDX_W  = $clog2(NCH_DEF);
    localparam int TMO_CNT_W = $clog2(TMO_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/byte_route_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
// The search starts one past the previous winner and wraps around.
module rr_arbiter #(
    parameter int NREQ = 8,
    parameter int RW   = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [RW-1:0]   last_grant,
    output logic [RW-1:0]   pick,
    output logic            any_req
);

    always_comb begin
        int idx;
        pick    = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(last_grant) + 1 + i) % NREQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                pick    = RW'(idx);
            end
        end
    end

endmodule

// File: rtl/byte_route_scheduler.sv
// Picks one requester round-robin, looks its byte up in the table and holds
// it on the chosen output channel until that channel is ready or times out.
module byte_route_scheduler
    import byte_route_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int NCH  = NCH_DEF,
    parameter int TMO  = TMO_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_sel,
    input  logic [2*NREQ-1:0]   req_ch,
    input  logic [2047:0]       tbl,
    output logic [NREQ-1:0]     grant,
    output logic [7:0]          out_data,
    output logic [NCH-1:0]      out_valid,
    input  logic [NCH-1:0]      out_ready,
    output logic                busy,
    output logic                err,
    input  logic                err_clr
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    state_t          r_state, w_next;
    logic [RW-1:0]   r_last;
    logic [NREQ-1:0] r_grant;
    logic [7:0]      r_data;
    logic [1:0]      r_ch;
    logic [NCH-1:0]  r_valid;
    logic [TW-1:0]   r_tmo;
    logic            r_err;

    logic [RW-1:0]   w_pick;
    logic            w_any;
    logic [7:0]      w_sel;
    logic [7:0]      w_byte;
    logic [1:0]      w_ch;
    logic            w_done;
    logic            w_tmo;

    rr_arbiter #(.NREQ(NREQ), .RW(RW)) u_arb (
        .req        (req),
        .last_grant (r_last),
        .pick       (w_pick),
        .any_req    (w_any)
    );

    assign w_sel  = req_sel[{w_pick, 3'b000} +: 8];
    assign w_byte = tbl[{w_sel, 3'b000} +: 8];
    assign w_ch   = req_ch[{w_pick, 1'b0} +: 2];

    // Ready on the expiry edge counts as completion, so timeout excludes it.
    assign w_done = (r_state == SEND) && out_ready[r_ch];
    assign w_tmo  = (r_state == SEND) && !out_ready[r_ch] && (r_tmo == TW'(TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = SEND;
            SEND:    if (w_done || w_tmo) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= RW'(NREQ - 1);
            r_grant <= '0;
            r_data  <= '0;
            r_ch    <= '0;
            r_valid <= '0;
            r_tmo   <= '0;
        end else begin
            r_grant <= '0;
            if (r_state == IDLE) begin
                if (w_any) begin
                    r_grant <= NREQ'(1) << w_pick;
                    r_data  <= w_byte;
                    r_ch    <= w_ch;
                    r_last  <= w_pick;
                    r_valid <= NCH'(1) << w_ch;
                    r_tmo   <= '0;
                end
            end else if (w_done || w_tmo) begin
                r_data  <= '0;
                r_valid <= '0;
                r_tmo   <= '0;
            end else begin
                r_tmo   <= r_tmo + 1'b1;
            end
        end
    end

    // A timeout on the same edge as err_clr leaves err set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_err <= 1'b0;
        else if (w_tmo)   r_err <= 1'b1;
        else if (err_clr) r_err <= 1'b0;
    end

    assign grant     = r_grant;
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign busy      = (r_state == SEND);
    assign err       = r_err;

endmodule

// File: doc/byte_route_scheduler.md
BYTE_ROUTE_SCHEDULER -- requirements
Module: byte_route_scheduler

Interface
REQ-001 Parameters SHALL be: NREQ, 8, number of requesters; NCH, 4, number of output channels; TMO, 16, cycles allowed for an out_ready response.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  NREQ  per-requester request level.
REQ-005 req_sel  input  8*NREQ  byte index per requester; requester i uses bits [8i+7:8i].
REQ-006 req_ch  input  2*NREQ  target channel per requester; requester i uses bits [2i+1:2i].
REQ-007 tbl  input  2048  256-entry byte table; entry k is tbl[8k+7:8k].
REQ-008 grant  output  NREQ  one-hot, one-cycle acknowledge pulse to the selected requester.
REQ-009 out_data  output  8  routed byte.
REQ-010 out_valid  output  NCH  one-hot valid, at most one bit set.
REQ-011 out_ready  input  NCH  per-channel ready.
REQ-012 busy  output  1  high while state is SEND.
REQ-013 err  output  1  sticky timeout flag.
REQ-014 err_clr  input  1  synchronous clear of err.

Function
REQ-015 The block SHALL have two states: IDLE and SEND.
REQ-016 In IDLE with req != 0, the block SHALL pick one requester round-robin, starting the search at (last_grant+1) mod NREQ.
REQ-017 On the pick edge, the block SHALL register: grant = onehot(pick); data = tbl[req_sel[pick]*8 +: 8]; ch = req_ch[pick]; last_grant = pick. It SHALL then enter SEND.
REQ-018 grant SHALL be high for exactly the first SEND cycle and zero at all other times.
REQ-019 Latency: req sampled high in IDLE at edge N SHALL produce grant and out_valid[ch] in the cycle after edge N.
REQ-020 In SEND, out_valid[ch] SHALL be 1, all other out_valid bits SHALL be 0, and out_data SHALL hold the captured byte, stable until the transfer completes.
REQ-021 A transfer SHALL complete on an edge where out_ready[ch] is 1; the block SHALL then return to IDLE, so the minimum spacing between grants is 2 cycles.
REQ-022 out_ready bits other than out_ready[ch] SHALL be ignored.
REQ-023 A timeout counter SHALL clear on entry to SEND and increment each SEND cycle. If TMO cycles elapse without completion, the block SHALL set err and return to IDLE, dropping the byte.
REQ-024 If ready arrives on the same edge as timeout expiry, ready SHALL win: the transfer completes and err is not set.
REQ-025 err_clr SHALL clear err. If err_clr and a new timeout occur on the same edge, set SHALL win.
REQ-026 Changes to tbl, req, req_sel or req_ch during SEND SHALL NOT affect out_data or ch.
REQ-027 Requesters still asserting req after grant SHALL be re-arbitrated as new requests.
REQ-028 Outside SEND, out_data SHALL be 0 and out_valid SHALL be 0.

Reset
REQ-029 While rst_n=0, the block SHALL immediately hold: state=IDLE, grant=0, out_valid=0, out_data=0, busy=0, err=0, timeout counter=0, last_grant=NREQ-1 (requester 0 has first priority).
REQ-030 Reset asserted mid-SEND SHALL abort the transfer with no err.
REQ-031 After reset deassertion, the first arbitration edge SHALL behave as in REQ-016.

Structure
REQ-032 Package byte_route_pkg SHALL hold the state enum (IDLE, SEND), the NREQ/NCH/TMO defaults, and the index width constants.
REQ-033 Sub-module rr_arbiter SHALL contain the combinational round-robin pick, with inputs req and last_grant and outputs pick index and any_req.
REQ-034 Output registers SHALL be used, with no combinational path from req or tbl to any output.

Verification
REQ-035 Reset, then req=8'h01, req_sel[0]=5, req_ch[0]=2, tbl entry 5=8'hA5, out_ready=4'hF -> next cycle: grant=8'h01, out_valid=4'b0100, out_data=8'hA5, busy=1; IDLE one cycle later.
REQ-036 req=8'hFF held, all out_ready=1 -> grants issued in order 0,1,...,7,0, one every 2 cycles.
REQ-037 Grant to channel 1 with out_ready=0 for 16 cycles -> err=1, out_valid=0, back in IDLE; pulse err_clr -> err=0.
REQ-038 out_ready[ch] raised on cycle 16 of SEND -> transfer completes and err stays 0; out_ready on other channels never completes a transfer.
REQ-039 Change tbl and req_sel mid-SEND -> out_data unchanged; rst_n low mid-SEND -> all outputs 0 immediately and next grant goes to requester 0.
